v810_ebi_ctrl: RTL and testbench
================================

# v810_ebi_ctrl

External bus interface controller for the V810 core's memory access unit. It watches the MAU's external bus cycle signals and decodes each address into one of four regions. It drives per-region chip selects and strobes, and generates READYn and SZRQn after a configurable wait-state count, so system memories and I/O need no handshake logic of their own. It also marks halt/fault acknowledge cycles and terminates accesses to unmapped regions with an error pulse.

## Interface
Parameters:
- WS_MAP, 12'h000: wait states per region, 3 bits each; region r uses WS_MAP[3r+2:3r] (0–7).
- DW16_MAP, 4'b0000: bit r set means region r is a 16-bit device.
- EN_MAP, 4'b1111: bit r set means region r is mapped.
- TIMEOUT, 15: wait states before an unmapped access is terminated (1–255).

Ports:
- CLK  in  1  system clock.
- RES  in  1  reset; asynchronous, active-high.
- CE  in  1  clock enable; all state advances only on CLK edges with CE=1.
- A  in  32  MAU address; region = A[31:30].
- ST  in  2  MAU bus status.
- BEn  in  4  byte enables, active-low.
- DAn  in  1  data strobe, active-low (T2 states).
- MRQn  in  1  memory request, active-low.
- RW  in  1  1=read, 0=write.
- BCYSTn  in  1  bus cycle start, active-low (T1).
- READYn  out  1  cycle termination to MAU, active-low.
- SZRQn  out  1  16-bit size request to MAU, active-low.
- CSn  out  4  per-region chip selects, active-low.
- OEn  out  1  read strobe, active-low.
- WEn  out  1  write strobe, active-low.
- HALT_ACK  out  1  one-cycle pulse on acknowledge-cycle completion.
- BUSERR  out  1  one-cycle pulse on unmapped-access termination.

## Operation
- States: IDLE, WAIT, ACKC.
- Cycle start: BCYSTn=0 in IDLE.
  - Latch the region, the wait count (WS_MAP entry, or TIMEOUT if unmapped), dw16, RW, and the ack flag.
  - Next state is WAIT, or ACKC for an acknowledge cycle.
- T1-bypass start: DAn=0 in IDLE with BCYSTn=1.
  - Latch from the current inputs as above.
  - This cycle counts as the first T2.
- Acknowledge cycle: MRQn=1 and ST[0]=1 at start.
  - CSn, OEn and WEn stay high.
  - 0-wait READYn.
  - HALT_ACK pulses in the cycle where READYn is low.
- WAIT state:
  - count>0: READYn=1; decrement the count on CE.
  - count=0: READYn=0.
  - On CE, return to IDLE, or restart directly if BCYSTn=0 in the same cycle (back-to-back).
- SZRQn = 0 together with READYn=0 when dw16 is set and BEn[3:2]≠2'b11 and BEn[1:0]≠2'b11 (a word spanning both halves). Otherwise SZRQn=1. The MAU runs the second half as a new cycle.
- Unmapped region:
  - CSn stays high.
  - READYn=0 after TIMEOUT waits.
  - BUSERR pulses with READYn.
- Strobes:
  - CSn[r]=0 during the start cycle (decoded combinationally from A) and for every WAIT cycle (latched region).
  - OEn=0 for reads and WEn=0 for writes over the same span.
  - The ack flag, or an unmapped region, suppresses all three.
- DAn rising in WAIT before termination: abort to IDLE, with no HALT_ACK or BUSERR.

## Timing
- Reset values: state IDLE, count 0, READYn=1, SZRQn=1, CSn=4'hF, OEn=1, WEn=1, HALT_ACK=0, BUSERR=0.
- RES asserted mid-cycle forces IDLE immediately; outputs return to their reset values asynchronously.
- READYn, SZRQn, CSn, OEn and WEn are combinational from state and latched fields, plus A/BEn in the start cycle.
- HALT_ACK and BUSERR are driven in the terminating cycle, not registered.
- Termination latency: a start at edge N gives READYn=0 in cycle N+1+WS, counting CE-qualified cycles only.
- T1-bypass start: READYn=0 in the detection cycle when WS=0.
- CE=0: state and count hold, and outputs hold their values.

## Structure
- Package v810_ebi_pkg holds:
  - the state enum (IDLE, WAIT, ACKC);
  - a region_t struct {en, dw16, ws[2:0]};
  - the ACK-cycle ST decode constant;
  - the helper function ws_of(region).
- One sub-module, v810_ebi_region_dec: combinational A[31:30] plus parameter maps to region_t. Everything else lives in v810_ebi_ctrl.

## Test plan
- Region 0 (WS=0, 32-bit) read at A=0x0000_0010:
  - READYn low in the first T2.
  - CSn=4'b1110, OEn=0, WEn=1, SZRQn=1.
- Region 2 (WS=3) write at A=0x8000_0004:
  - READYn high for 3 T2 cycles, then low for one.
  - WEn=0 throughout.
  - Repeat with CE toggling 1/0: termination stretches to 6 clocks.
- Region 1 (DW16) word read at BEn=4'b0000: SZRQn=0 with READYn. A halfword read at BEn=4'b1100 gives SZRQn=1.
- Acknowledge cycle (MRQn=1, ST=2'b01, DAn=0):
  - READYn=0 and HALT_ACK=1 for one cycle.
  - CSn=4'hF, OEn=WEn=1.
- EN_MAP=4'b0111, access at A=0xC000_0000: READYn=0 and BUSERR=1 after 15 waits, CSn=4'hF.
- Back-to-back BCYSTn=0 in the READYn cycle starts a new WAIT without visiting IDLE. RES pulsed at wait 2 of WS=3 gives READYn=1 and CSn=4'hF immediately.

Source files
------------

// File: rtl/v810_ebi_pkg.sv
// Shared types and helpers for the V810 external bus interface controller.
package v810_ebi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACKC = 2'd2
  } state_t;

  typedef struct packed {
    logic       en;
    logic       dw16;
    logic [2:0] ws;
  } region_t;

  // An acknowledge cycle is MRQn high with this ST bit set.
  localparam int unsigned ACK_ST_BIT = 0;

  function automatic logic [7:0] ws_of(input region_t r, input logic [7:0] timeout);
    return r.en ? {5'd0, r.ws} : timeout;
  endfunction

endpackage

// File: rtl/v810_ebi_region_dec.sv
// Maps the top two address bits onto the region attributes held in the parameter maps.
module v810_ebi_region_dec
  import v810_ebi_pkg::*;
#(
  parameter logic [11:0] WS_MAP   = 12'h000,
  parameter logic [3:0]  DW16_MAP = 4'b0000,
  parameter logic [3:0]  EN_MAP   = 4'b1111
) (
  input  logic [1:0] sel_i,
  output region_t    region_o
);

  region_t tbl [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_tbl
    assign tbl[gi] = {EN_MAP[gi], DW16_MAP[gi], WS_MAP[3*gi +: 3]};
  end

  assign region_o = tbl[sel_i];

endmodule

// File: rtl/v810_ebi_ctrl.sv
// Bus-cycle tracker for the V810 MAU: region chip selects, strobes, wait-state
// READYn/SZRQn generation, halt/fault acknowledge and unmapped-access termination.
module v810_ebi_ctrl
  import v810_ebi_pkg::*;
#(
  parameter logic [11:0] WS_MAP   = 12'h000,
  parameter logic [3:0]  DW16_MAP = 4'b0000,
  parameter logic [3:0]  EN_MAP   = 4'b1111,
  parameter int          TIMEOUT  = 15
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] A,
  input  logic [1:0]  ST,
  input  logic [3:0]  BEn,
  input  logic        DAn,
  input  logic        MRQn,
  input  logic        RW,
  input  logic        BCYSTn,
  output logic        READYn,
  output logic        SZRQn,
  output logic [3:0]  CSn,
  output logic        OEn,
  output logic        WEn,
  output logic        HALT_ACK,
  output logic        BUSERR
);

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [1:0] region_q, region_d;
  logic       dw16_q, dw16_d;
  logic       rw_q, rw_d;
  logic       en_q, en_d;

  region_t    cur_reg;
  logic       cur_ack;
  logic [7:0] cur_cnt;
  logic       load, load_byp;
  logic       strobe_on, strobe_rw;
  logic [1:0] strobe_reg;
  logic       unused_in;

  v810_ebi_region_dec #(
    .WS_MAP  (WS_MAP),
    .DW16_MAP(DW16_MAP),
    .EN_MAP  (EN_MAP)
  ) u_dec (
    .sel_i   (A[31:30]),
    .region_o(cur_reg)
  );

  assign unused_in = ^{A[29:0], ST[1]};
  assign cur_ack   = MRQn & ST[ACK_ST_BIT];
  assign cur_cnt   = cur_ack ? 8'd0 : ws_of(cur_reg, TIMEOUT_W);

  // A 16-bit device cannot complete a word that touches both halves in one go.
  function automatic logic span_both(input logic dw16, input logic [3:0] ben);
    return dw16 && (ben[3:2] != 2'b11) && (ben[1:0] != 2'b11);
  endfunction

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    region_d   = region_q;
    dw16_d     = dw16_q;
    rw_d       = rw_q;
    en_d       = en_q;
    load       = 1'b0;
    load_byp   = 1'b0;
    strobe_on  = 1'b0;
    strobe_reg = region_q;
    strobe_rw  = rw_q;
    READYn     = 1'b1;
    SZRQn      = 1'b1;
    CSn        = 4'hF;
    OEn        = 1'b1;
    WEn        = 1'b1;
    HALT_ACK   = 1'b0;
    BUSERR     = 1'b0;

    if (!RES) begin
      unique case (state_q)
        IDLE: begin
          if (!BCYSTn || !DAn) begin
            strobe_on  = cur_reg.en & ~cur_ack;
            strobe_reg = A[31:30];
            strobe_rw  = RW;
            if (!BCYSTn) begin
              load    = 1'b1;
              state_d = cur_ack ? ACKC : WAIT;
            end else if (cur_cnt == 8'd0) begin
              // Bypass start with nothing to wait for terminates in place.
              READYn   = 1'b0;
              SZRQn    = ~span_both(cur_reg.dw16, BEn);
              HALT_ACK = cur_ack;
              BUSERR   = ~cur_ack & ~cur_reg.en;
            end else begin
              load     = 1'b1;
              load_byp = 1'b1;
              state_d  = WAIT;
            end
          end
        end
        WAIT: begin
          strobe_on = en_q;
          if (count_q == 8'd0) begin
            READYn  = 1'b0;
            SZRQn   = ~span_both(dw16_q, BEn);
            BUSERR  = ~en_q;
            state_d = IDLE;
            if (!BCYSTn) begin
              load    = 1'b1;
              state_d = cur_ack ? ACKC : WAIT;
            end
          end else if (DAn) begin
            state_d = IDLE;
          end else begin
            count_d = count_q - 8'd1;
          end
        end
        ACKC: begin
          READYn   = 1'b0;
          HALT_ACK = 1'b1;
          state_d  = IDLE;
          if (!BCYSTn) begin
            load    = 1'b1;
            state_d = cur_ack ? ACKC : WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      region_d = A[31:30];
      count_d  = load_byp ? cur_cnt - 8'd1 : cur_cnt;
      dw16_d   = cur_reg.dw16;
      rw_d     = RW;
      en_d     = cur_reg.en;
    end

    if (strobe_on) begin
      CSn[strobe_reg] = 1'b0;
      OEn             = ~strobe_rw;
      WEn             = strobe_rw;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q  <= IDLE;
      count_q  <= 8'd0;
      region_q <= 2'd0;
      dw16_q   <= 1'b0;
      rw_q     <= 1'b1;
      en_q     <= 1'b0;
    end else if (CE) begin
      state_q  <= state_d;
      count_q  <= count_d;
      region_q <= region_d;
      dw16_q   <= dw16_d;
      rw_q     <= rw_d;
      en_q     <= en_d;
    end
  end

endmodule

// File: tb/tb_v810_ebi_ctrl.sv
// Directed bench for v810_ebi_ctrl: region 0 WS0, region 1 16-bit, region 2 WS3, region 3 unmapped.
module tb_v810_ebi_ctrl;

  logic        CLK, RES, CE;
  logic [31:0] A;
  logic [1:0]  ST;
  logic [3:0]  BEn;
  logic        DAn, MRQn, RW, BCYSTn;
  logic        READYn, SZRQn, OEn, WEn, HALT_ACK, BUSERR;
  logic [3:0]  CSn;

  int checks = 0;
  int errors = 0;

  v810_ebi_ctrl #(
    .WS_MAP  (12'h0C0),
    .DW16_MAP(4'b0010),
    .EN_MAP  (4'b0111),
    .TIMEOUT (15)
  ) dut (
    .CLK(CLK), .RES(RES), .CE(CE), .A(A), .ST(ST), .BEn(BEn), .DAn(DAn),
    .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn), .READYn(READYn), .SZRQn(SZRQn),
    .CSn(CSn), .OEn(OEn), .WEn(WEn), .HALT_ACK(HALT_ACK), .BUSERR(BUSERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_all(input string tag, input logic rdy, input logic sz, input logic [3:0] cs,
                         input logic oe, input logic we, input logic ha, input logic be);
    check({tag, ".READYn"},   READYn,   rdy);
    check({tag, ".SZRQn"},    SZRQn,    sz);
    check({tag, ".CSn"},      CSn,      cs);
    check({tag, ".OEn"},      OEn,      oe);
    check({tag, ".WEn"},      WEn,      we);
    check({tag, ".HALT_ACK"}, HALT_ACK, ha);
    check({tag, ".BUSERR"},   BUSERR,   be);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in;
    CE = 1'b1; A = 32'h0; ST = 2'b00; BEn = 4'h0; DAn = 1'b1;
    MRQn = 1'b0; RW = 1'b1; BCYSTn = 1'b1;
  endtask

  logic ce_seq [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    RES = 1'b1;
    idle_in();
    #2;
    exp_all("reset", 1, 1, 4'hF, 1, 1, 0, 0);
    tick();
    RES = 1'b0;
    $display("txn reset");

    // Region 0 read, zero waits
    A = 32'h0000_0010; RW = 1'b1; BCYSTn = 1'b0; #1;
    exp_all("r0_t1", 1, 1, 4'hE, 0, 1, 0, 0);
    tick(); BCYSTn = 1'b1; DAn = 1'b0; #1;
    exp_all("r0_t2", 0, 1, 4'hE, 0, 1, 0, 0);
    tick(); idle_in(); #1;
    exp_all("r0_idle", 1, 1, 4'hF, 1, 1, 0, 0);
    $display("txn r0_read");

    // Region 2 write, three waits
    A = 32'h8000_0004; RW = 1'b0; BCYSTn = 1'b0; #1;
    exp_all("r2_t1", 1, 1, 4'hB, 1, 0, 0, 0);
    tick(); BCYSTn = 1'b1; DAn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; exp_all("r2_wait", 1, 1, 4'hB, 1, 0, 0, 0);
      tick();
    end
    #1; exp_all("r2_rdy", 0, 1, 4'hB, 1, 0, 0, 0);
    tick(); idle_in(); #1;
    check("r2_idle.CSn", CSn, 4'hF);
    $display("txn r2_write");

    // Same write with CE toggling: READYn low on the sixth clock
    A = 32'h8000_0004; RW = 1'b0; BCYSTn = 1'b0;
    tick(); BCYSTn = 1'b1; DAn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      CE = ce_seq[i]; #1;
      check("ce_stretch.READYn", READYn, (i == 5) ? 1'b0 : 1'b1);
      tick();
    end
    idle_in();
    $display("txn r2_write_ce");

    // Region 1 16-bit: word spans both halves, halfword does not
    A = 32'h4000_0000; RW = 1'b1; BEn = 4'b0000; BCYSTn = 1'b0;
    tick(); BCYSTn = 1'b1; DAn = 1'b0; #1;
    exp_all("dw_word", 0, 0, 4'hD, 0, 1, 0, 0);
    tick(); idle_in();
    A = 32'h4000_0000; BEn = 4'b1100; BCYSTn = 1'b0;
    tick(); BCYSTn = 1'b1; DAn = 1'b0; #1;
    exp_all("dw_half", 0, 1, 4'hD, 0, 1, 0, 0);
    tick(); idle_in();
    $display("txn r1_dw16");

    // Acknowledge cycle via T1 bypass
    MRQn = 1'b1; ST = 2'b01; DAn = 1'b0; #1;
    exp_all("ack", 0, 1, 4'hF, 1, 1, 1, 0);
    tick(); idle_in(); #1;
    exp_all("ack_end", 1, 1, 4'hF, 1, 1, 0, 0);
    $display("txn ack");

    // Unmapped region 3: terminated after 15 waits
    A = 32'hC000_0000; RW = 1'b1; BCYSTn = 1'b0; #1;
    check("um_t1.CSn", CSn, 4'hF);
    tick(); BCYSTn = 1'b1; DAn = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      check("um_wait.READYn", READYn, 1'b1);
      check("um_wait.BUSERR", BUSERR, 1'b0);
      tick();
    end
    #1; exp_all("um_term", 0, 1, 4'hF, 1, 1, 0, 1);
    tick(); idle_in(); #1;
    check("um_end.BUSERR", BUSERR, 1'b0);
    $display("txn unmapped");

    // Back-to-back: region 0 read chained into region 2 write
    A = 32'h0000_0010; RW = 1'b1; BCYSTn = 1'b0;
    tick(); BCYSTn = 1'b1; DAn = 1'b0; #1;
    check("b2b_first.READYn", READYn, 1'b0);
    A = 32'h8000_0000; RW = 1'b0; BCYSTn = 1'b0;
    tick(); BCYSTn = 1'b1; DAn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("b2b_wait.READYn", READYn, 1'b1);
      check("b2b_wait.CSn", CSn, 4'hB);
      check("b2b_wait.WEn", WEn, 1'b0);
      tick();
    end
    #1; check("b2b_rdy.READYn", READYn, 1'b0);
    tick(); idle_in();
    $display("txn back_to_back");

    // T1-bypass read on region 2: detection cycle is the first T2
    A = 32'h8000_0008; RW = 1'b1; DAn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("byp_wait.READYn", READYn, 1'b1);
      check("byp_wait.OEn", OEn, 1'b0);
      tick();
    end
    #1; exp_all("byp_rdy", 0, 1, 4'hB, 0, 1, 0, 0);
    tick(); idle_in();
    $display("txn bypass");

    // DAn released mid-wait aborts without termination
    A = 32'h8000_0000; RW = 1'b1; BCYSTn = 1'b0;
    tick(); BCYSTn = 1'b1; DAn = 1'b0; #1;
    check("abort_w1.READYn", READYn, 1'b1);
    tick(); DAn = 1'b1;
    tick(); #1;
    exp_all("abort_idle", 1, 1, 4'hF, 1, 1, 0, 0);
    $display("txn abort");

    // Reset at wait 2 of a WS=3 write
    A = 32'h8000_0000; RW = 1'b0; BCYSTn = 1'b0;
    tick(); BCYSTn = 1'b1; DAn = 1'b0;
    tick(); #1;
    check("rst_mid_pre.CSn", CSn, 4'hB);
    RES = 1'b1; #1;
    exp_all("rst_mid", 1, 1, 4'hF, 1, 1, 0, 0);
    DAn = 1'b1;
    tick(); RES = 1'b0; idle_in();
    A = 32'h0000_0010; RW = 1'b1; BCYSTn = 1'b0;
    tick(); BCYSTn = 1'b1; DAn = 1'b0; #1;
    exp_all("post_rst_r0", 0, 1, 4'hE, 0, 1, 0, 0);
    tick(); idle_in();
    $display("txn reset_mid_wait");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
